// File: rtl/fc_neuron_engine.sv
// -----------------------------------------------------------------------------
// fc_neuron_engine
//   Streaming int8 fully-connected neuron. It accumulates
//   (act - input_zp) * (wgt - filter_zp) over a burst of beats that ends with
//   i_last. It then adds the bias, optionally applies ReLU, and requantizes with
//   a fixed-point multiplier and a rounding right shift. The int8 result is
//   presented on a valid/ready output handshake.
//
//   Optional feature macro: OUT_CLAMP_EN
//     defined   : the final value saturates to -128..127
//     undefined : the final value is truncated to its low 8 bits, which is
//                 bit-exact with the golden MNIST model
//
// Ports
//   i_clk, i_rst_n          clock, async active-low reset
//   i_valid / o_ready       input beat handshake (o_ready high only in ACC)
//   i_act, i_wgt            signed int8 activation / weight
//   i_last                  final beat of the neuron
//   i_bias, i_quant_mult    signed 32-bit bias / multiplier (sampled on i_last)
//   i_quant_shift           signed shift -32..30 (sampled on i_last)
//   i_relu_en               clamp negative pre-quant sums to 0 (sampled on i_last)
//   i_input_zp, i_filter_zp, i_output_zp  signed int8 zero points
//   o_valid / i_ready       result handshake
//   o_out                   requantized int8 result
//   o_beats                 beats accepted for the emitted neuron (wraps)
// -----------------------------------------------------------------------------
module fc_neuron_engine #(
  parameter int unsigned CNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [7:0]         i_act,
  input  logic [7:0]         i_wgt,
  input  logic               i_last,
  input  logic [31:0]        i_bias,
  input  logic [7:0]         i_input_zp,
  input  logic [7:0]         i_filter_zp,
  input  logic [7:0]         i_output_zp,
  input  logic [31:0]        i_quant_mult,
  input  logic [7:0]         i_quant_shift,
  input  logic               i_relu_en,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [7:0]         o_out,
  output logic [CNT_W-1:0]   o_beats
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OFF_W  = 16;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned PROD_W = 64;

  typedef enum logic [2:0] {
    ST_ACC   = 3'd0,
    ST_BIAS  = 3'd1,
    ST_MUL   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  state_e                    state_q,  state_d;
  logic signed [ACC_W-1:0]   acc_q,    acc_d;
  logic [CNT_W-1:0]          beats_q,  beats_d;
  logic signed [ACC_W-1:0]   bias_q,   bias_d;
  logic signed [ACC_W-1:0]   mult_q,   mult_d;
  logic [DATA_W-1:0]         shift_q,  shift_d;
  logic                      relu_q,   relu_d;
  logic signed [PROD_W-1:0]  p_q,      p_d;
  logic [DATA_W-1:0]         out_q,    out_d;
  logic                      valid_q,  valid_d;
  logic                      ready_q,  ready_d;

  logic signed [OFF_W-1:0]   act_off;
  logic signed [OFF_W-1:0]   wgt_off;
  logic signed [ACC_W-1:0]   beat_prod;
  logic signed [ACC_W-1:0]   bias_sum;
  logic signed [ACC_W-1:0]   relu_val;
  logic [DATA_W-1:0]         t_amt;
  logic signed [PROD_W-1:0]  rnd;
  logic signed [PROD_W-1:0]  p_next;
  logic [DATA_W-1:0]         out_res;
`ifdef OUT_CLAMP_EN
  logic signed [PROD_W-1:0]  out_wide;
`endif

  // Zero-point corrected beat product.
  always_comb begin
    act_off   = OFF_W'($signed(i_act)) - OFF_W'($signed(i_input_zp));
    wgt_off   = OFF_W'($signed(i_wgt)) - OFF_W'($signed(i_filter_zp));
    beat_prod = ACC_W'(act_off) * ACC_W'(wgt_off);
  end

  // Bias add and optional ReLU.
  always_comb begin
    bias_sum = acc_q + bias_q;
    relu_val = (relu_q && (bias_sum < 0)) ? '0 : bias_sum;
  end

  // t = 31 - shift lies in 1..63 for the legal shift range; the mod-256
  // subtraction produces it directly from the two's-complement shift.
  always_comb begin
    t_amt  = DATA_W'(8'd31 - shift_q);
    rnd    = $signed(PROD_W'(1) << (t_amt - DATA_W'(1)));
    p_next = PROD_W'(acc_q) * PROD_W'(mult_q) + rnd;
  end

  // Output reduction. Saturation is taken from the full-width value so that a
  // large positive result does not alias into the negative range first.
`ifdef OUT_CLAMP_EN
  always_comb begin
    out_wide = (p_q >>> t_amt) + PROD_W'($signed(i_output_zp));
    if (out_wide > 64'sd127) begin
      out_res = 8'h7F;
    end else if (out_wide < -64'sd128) begin
      out_res = 8'h80;
    end else begin
      out_res = DATA_W'(out_wide);
    end
  end
`else
  always_comb begin
    out_res = DATA_W'(p_q >>> t_amt) + i_output_zp;
  end
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    beats_d = beats_q;
    bias_d  = bias_q;
    mult_d  = mult_q;
    shift_d = shift_q;
    relu_d  = relu_q;
    p_d     = p_q;
    out_d   = out_q;
    valid_d = valid_q;

    case (state_q)
      ST_ACC: begin
        if (i_valid) begin
          acc_d   = acc_q + beat_prod;
          beats_d = beats_q + CNT_W'(1);
          if (i_last) begin
            bias_d  = $signed(i_bias);
            mult_d  = $signed(i_quant_mult);
            shift_d = i_quant_shift;
            relu_d  = i_relu_en;
            state_d = ST_BIAS;
          end
        end
      end
      ST_BIAS: begin
        // The accumulator is reused to hold the rectified, biased sum.
        acc_d   = relu_val;
        state_d = ST_MUL;
      end
      ST_MUL: begin
        p_d     = p_next;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        out_d   = out_res;
        valid_d = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (i_ready) begin
          valid_d = 1'b0;
          acc_d   = '0;
          beats_d = '0;
          state_d = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase

    ready_d = (state_d == ST_ACC);
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      beats_q <= '0;
      bias_q  <= '0;
      mult_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      p_q     <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      beats_q <= beats_d;
      bias_q  <= bias_d;
      mult_q  <= mult_d;
      shift_q <= shift_d;
      relu_q  <= relu_d;
      p_q     <= p_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_out   = out_q;
  assign o_beats = beats_q;

endmodule
